// File: rtl/wb_write_seq_pkg.sv
// Shared types and constants for the write-back sequencer and its queue.
package wb_write_seq_pkg;
    localparam int CODE_W = 4;
    localparam int WB_DW  = 32;
    localparam logic [CODE_W-1:0] REG_PC = 4'hF;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [WB_DW-1:0]  data;
    } wb_entry_t;

    function automatic logic [15:0] code_onehot(input logic [CODE_W-1:0] code);
        code_onehot = 16'h0001 << code;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Write-back queue: up to two pushes and one pop per cycle, with per-slot
// visibility so the top can build the pending-register mask.
module wb_fifo
    import wb_write_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               push_n,
    input  logic [CODE_W-1:0]        push0_code,
    input  logic [DW-1:0]            push0_data,
    input  logic [CODE_W-1:0]        push1_code,
    input  logic [DW-1:0]            push1_data,
    input  logic                     pop,
    output logic [CW-1:0]            count,
    output logic [CODE_W-1:0]        head_code,
    output logic [DW-1:0]            head_data,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [DEPTH*CODE_W-1:0]  ent_code
);
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CODE_W-1:0] code_mem_r [DEPTH];
    logic [DW-1:0]     data_mem_r [DEPTH];

    // Storage, pointers and occupancy; a pair of pushes lands in consecutive slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                code_mem_r[k] <= '0;
                data_mem_r[k] <= '0;
            end
        end else begin
            if (push_n != 2'd0) begin
                code_mem_r[wr_ptr_r] <= push0_code;
                data_mem_r[wr_ptr_r] <= push0_data;
            end
            if (push_n == 2'd2) begin
                code_mem_r[wr_ptr_r + AW'(1)] <= push1_code;
                data_mem_r[wr_ptr_r + AW'(1)] <= push1_data;
            end
            wr_ptr_r <= wr_ptr_r + AW'(push_n);
            rd_ptr_r <= rd_ptr_r + AW'(pop);
            count_r  <= count_r + CW'(push_n) - CW'(pop);
        end
    end

    // A slot is live when its wrapped distance from the read pointer is below the count.
    always_comb begin
        ent_valid = '0;
        ent_code  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = ({1'b0, AW'(k) - rd_ptr_r} < count_r);
            ent_code[k*CODE_W +: CODE_W] = code_mem_r[k];
        end
    end

    assign count     = count_r;
    assign head_code = code_mem_r[rd_ptr_r];
    assign head_data = data_mem_r[rd_ptr_r];
endmodule

// File: rtl/wb_write_seq_chk.sv
// Occupancy checker for the write-back queue: no overflow, no pop from empty.
module wb_write_seq_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          pop,
    input logic [1:0]    push_n
);
    localparam int NW = CW + 1;
    logic [NW-1:0] next_count_s;

    assign next_count_s = NW'(count) + NW'(push_n) - NW'(pop);

    // Every active edge must keep the queue within its capacity.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (next_count_s <= NW'(DEPTH));
            assert (!(pop && (count == '0)));
        end
    end
endmodule

// File: rtl/wb_write_seq.sv
// Write-back sequencer: expands each retiring instruction into up to two
// register writes and serializes them onto the single register-file port.
module wb_write_seq
    import wb_write_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_wr0_en,
    input  logic [3:0]        i_wr0_code,
    input  logic [DW-1:0]     i_wr0_data,
    input  logic              i_wr1_en,
    input  logic [3:0]        i_wr1_code,
    input  logic [DW-1:0]     i_wr1_data,
    output logic              o_rd_en_wb,
    output logic [3:0]        o_rd_code_wb,
    output logic [DW-1:0]     o_rd_reg_wb,
    output logic              o_pc_wr,
    output logic [15:0]       o_pend_mask,
    output logic              o_idle
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]            count_s;
    logic [CW-1:0]            free_s;
    logic [CODE_W-1:0]        head_code_s;
    logic [DW-1:0]            head_data_s;
    logic [DEPTH-1:0]         ent_valid_s;
    logic [DEPTH*CODE_W-1:0]  ent_code_s;
    logic                     ready_s;
    logic                     accept_s;
    logic                     empty_s;
    logic                     pop_s;
    logic                     load_en_s;
    logic                     inc0_en_s;
    logic                     inc1_en_s;
    logic [CODE_W-1:0]        inc0_code_s;
    logic [DW-1:0]            inc0_data_s;
    logic [CODE_W-1:0]        load_code_s;
    logic [DW-1:0]            load_data_s;
    logic [CODE_W-1:0]        push0_code_s;
    logic [DW-1:0]            push0_data_s;
    logic [1:0]               push_n_s;
    logic [15:0]              mask_s;
    logic                     rd_en_r;
    logic [CODE_W-1:0]        rd_code_r;
    logic [DW-1:0]            rd_reg_r;

    // Two free slots are always reserved so a dual write can never overflow.
    assign free_s   = CW'(DEPTH) - count_s;
    assign ready_s  = (free_s >= CW'(2));
    assign accept_s = i_valid & ready_s;
    assign empty_s  = (count_s == '0);

    // Compact the request, then choose between the queue head and the bypass path.
    always_comb begin
        inc0_en_s    = accept_s & (i_wr0_en | i_wr1_en);
        inc1_en_s    = accept_s & i_wr0_en & i_wr1_en;
        inc0_code_s  = i_wr0_code;
        inc0_data_s  = i_wr0_data;
        pop_s        = 1'b0;
        load_en_s    = 1'b0;
        load_code_s  = head_code_s;
        load_data_s  = head_data_s;
        push0_code_s = i_wr0_code;
        push0_data_s = i_wr0_data;
        push_n_s     = 2'd0;
        if (i_wr0_en) begin
            inc0_code_s = i_wr0_code;
            inc0_data_s = i_wr0_data;
        end else begin
            inc0_code_s = i_wr1_code;
            inc0_data_s = i_wr1_data;
        end
        if (!empty_s) begin
            pop_s        = 1'b1;
            load_en_s    = 1'b1;
            push0_code_s = inc0_code_s;
            push0_data_s = inc0_data_s;
            push_n_s     = {1'b0, inc0_en_s} + {1'b0, inc1_en_s};
        end else begin
            load_en_s    = inc0_en_s;
            load_code_s  = inc0_code_s;
            load_data_s  = inc0_data_s;
            push0_code_s = i_wr1_code;
            push0_data_s = i_wr1_data;
            push_n_s     = {1'b0, inc1_en_s};
        end
    end

    wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .push_n     (push_n_s),
        .push0_code (push0_code_s),
        .push0_data (push0_data_s),
        .push1_code (i_wr1_code),
        .push1_data (i_wr1_data),
        .pop        (pop_s),
        .count      (count_s),
        .head_code  (head_code_s),
        .head_data  (head_data_s),
        .ent_valid  (ent_valid_s),
        .ent_code   (ent_code_s)
    );

    wb_write_seq_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .count  (count_s),
        .pop    (pop_s),
        .push_n (push_n_s)
    );

    // Write-port register; code and data hold when no entry is available.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_en_r   <= 1'b0;
            rd_code_r <= '0;
            rd_reg_r  <= '0;
        end else if (load_en_s) begin
            rd_en_r   <= 1'b1;
            rd_code_r <= load_code_s;
            rd_reg_r  <= load_data_s;
        end else begin
            rd_en_r   <= 1'b0;
        end
    end

    // Pending mask covers queued entries only; the port entry is forwarded instead.
    always_comb begin
        mask_s = 16'h0000;
        for (int k = 0; k < DEPTH; k++) begin
            mask_s = mask_s | (ent_valid_s[k] ? code_onehot(ent_code_s[k*CODE_W +: CODE_W])
                                              : 16'h0000);
        end
    end

    assign o_ready      = ready_s;
    assign o_rd_en_wb   = rd_en_r;
    assign o_rd_code_wb = rd_code_r;
    assign o_rd_reg_wb  = rd_reg_r;
    assign o_pc_wr      = rd_en_r & (rd_code_r == REG_PC);
    assign o_pend_mask  = mask_s;
    assign o_idle       = empty_s & ~rd_en_r;
endmodule
